// File: rtl/trace_pkg.sv
// Shared definitions for the writeback trace buffer: record field widths,
// bit offsets inside a record, and the drop-counter width.
package trace_pkg;

    localparam int unsigned REG_W         = 5;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned SEQ_W_DEFAULT = 11;
    localparam int unsigned DROP_W        = 16;

    // Record layout, LSB first: {seq, reg, data}
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned REG_LSB  = DATA_LSB + DATA_W;
    localparam int unsigned SEQ_LSB  = REG_LSB + REG_W;

    function automatic int unsigned record_width(input int unsigned seq_w);
        return seq_w + REG_W + DATA_W;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic DEPTH x WIDTH register-array FIFO with push/pop/clear and occupancy.
// No fall-through: a pushed entry becomes visible on the edge after the push.
module trace_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WIDTH  = 48
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign o_count   = r_count;
    assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when the same edge frees a slot.
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clear;

    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures eligible regfile writebacks as sequence-tagged records into a FIFO
// and drains them over valid/ready; drops on full are counted and flagged.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned SEQ_W  = SEQ_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ctrl_writeEnable,
    input  logic [REG_W-1:0]      ctrl_writeReg,
    input  logic [DATA_W-1:0]     data_writeReg,
    input  logic                  capture_en,
    input  logic                  clear,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [SEQ_W+36:0]     out_data,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int unsigned REC_W = SEQ_W + REG_W + DATA_W;

    logic [SEQ_W-1:0]  r_seq;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    logic              w_eligible;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [REC_W-1:0]  w_record;
    logic [REC_W-1:0]  w_rdata;
    logic [ADDR_W:0]   w_count;

    assign w_eligible = capture_en & ctrl_writeEnable & (ctrl_writeReg != '0);
    assign w_pop      = ~w_empty & out_ready;
    assign w_push     = w_eligible & (~w_full | w_pop);
    assign w_drop     = w_eligible & w_full & ~w_pop;
    assign w_record   = {r_seq, ctrl_writeReg, data_writeReg};

    trace_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (REC_W)
    ) u_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (clear),
        .i_wdata (w_record),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid  = ~w_empty;
    assign out_data   = w_rdata;
    assign count      = w_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // Every eligible event burns a sequence number, stored or dropped, so the
    // host can spot drops as gaps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_seq        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_seq        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_eligible) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed-vector bench for wb_trace_buffer with hand-computed expectations.
module tb_wb_trace_buffer;

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        capture_en;
    logic        clear;
    logic        out_ready;
    logic        out_valid;
    logic [47:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    int unsigned n_checks;
    int unsigned n_errors;

    wb_trace_buffer #(
        .DEPTH  (16),
        .ADDR_W (4),
        .SEQ_W  (11)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .capture_en       (capture_en),
        .clear            (clear),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .count            (count),
        .overflow         (overflow),
        .drop_count       (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] rec(input int unsigned seq, input logic [4:0] r, input logic [31:0] d);
        logic [10:0] s;
        s = 11'(seq);
        return {s, r, d};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = r;
        data_writeReg    = d;
        tick();
        ctrl_writeEnable = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg = '0;
        data_writeReg = '0;
        capture_en = 1'b1;
        clear = 1'b0;
        out_ready = 1'b0;

        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_drop",  64'(drop_count), 64'd0);
        #9 reset = 1'b1;
        tick();

        // Single write, no fall-through, then one pop
        check("pre_valid", 64'(out_valid), 64'd0);
        wr(5'd3, 32'h0000_00AA);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data",  64'(out_data), 64'(rec(0, 5'd3, 32'hAA)));
        check("t1_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_pop_count", 64'(count), 64'd0);
        check("t1_pop_valid", 64'(out_valid), 64'd0);

        // r0 filtered, seq continues from 0 after clear
        do_clear();
        wr(5'd0, 32'hFFFF_FFFF);
        check("t2_r0_count", 64'(count), 64'd0);
        wr(5'd1, 32'h5);
        wr(5'd2, 32'h6);
        check("t2_count", 64'(count), 64'd2);
        check("t2_rec0", 64'(out_data), 64'(rec(0, 5'd1, 32'h5)));
        out_ready = 1'b1;
        tick();
        check("t2_rec1", 64'(out_data), 64'(rec(1, 5'd2, 32'h6)));
        tick();
        out_ready = 1'b0;
        check("t2_empty", 64'(out_valid), 64'd0);

        // capture_en low: writebacks ignored, seq not consumed
        capture_en = 1'b0;
        wr(5'd7, 32'h77);
        check("cap_off_count", 64'(count), 64'd0);
        capture_en = 1'b1;

        // Overflow: 20 writes into 16 entries
        do_clear();
        for (int i = 0; i < 20; i++) begin
            wr(5'((i % 31) + 1), 32'h1000 + 32'(i));
        end
        check("t3_count", 64'(count), 64'd16);
        check("t3_ovf",   64'(overflow), 64'd1);
        check("t3_drop",  64'(drop_count), 64'd4);
        check("t3_head",  64'(out_data), 64'(rec(0, 5'd1, 32'h1000)));

        // Full with simultaneous pop and push: write #21 accepted with seq 20
        out_ready = 1'b1;
        wr(5'd21, 32'h1014);
        check("t4_count", 64'(count), 64'd16);
        check("t4_drop",  64'(drop_count), 64'd4);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t4_drain%0d", i), 64'(out_data),
                  64'(rec(i, 5'((i % 31) + 1), 32'h1000 + 32'(i))));
            tick();
        end
        check("t4_wrap_rec", 64'(out_data), 64'(rec(20, 5'd21, 32'h1014)));
        tick();
        out_ready = 1'b0;
        check("t4_empty_count", 64'(count), 64'd0);
        check("t4_empty_valid", 64'(out_valid), 64'd0);
        check("t4_ovf_sticky", 64'(overflow), 64'd1);

        // Clear with count=7 and a simultaneous write + pop request
        for (int i = 0; i < 7; i++) begin
            wr(5'd4, 32'h2000 + 32'(i));
        end
        check("t5_pre_count", 64'(count), 64'd7);
        clear = 1'b1;
        out_ready = 1'b1;
        wr(5'd9, 32'h9999);
        clear = 1'b0;
        out_ready = 1'b0;
        check("t5_count", 64'(count), 64'd0);
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_ovf",   64'(overflow), 64'd0);
        check("t5_drop",  64'(drop_count), 64'd0);
        wr(5'd10, 32'hABCD);
        check("t5_seq0", 64'(out_data), 64'(rec(0, 5'd10, 32'hABCD)));

        // Asynchronous reset mid-stream, overflow set beforehand
        for (int i = 0; i < 17; i++) begin
            wr(5'd11, 32'(i));
        end
        check("t6_pre_ovf", 64'(overflow), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_ovf",   64'(overflow), 64'd0);
        check("t6_drop",  64'(drop_count), 64'd0);
        #3 reset = 1'b1;
        tick();
        wr(5'd12, 32'hCAFE);
        check("t6_seq0", 64'(out_data), 64'(rec(0, 5'd12, 32'hCAFE)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Downstream consumer of the processor/regfile write port exported by the top level (ctrl_writeEnable, ctrl_writeReg, data_writeReg).
- Captures every architectural register writeback into a small FIFO as a sequence-tagged record.
- Drains records to a test host over a valid/ready interface.
- Clocked by regfile_clock, so exactly one sample is taken per regfile write edge.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- SEQ_W, 11, width of the writeback sequence tag.

Ports:
- clock  in  1  rising-edge clock; connect to regfile_clock.
- reset  in  1  asynchronous, active-low reset.
- ctrl_writeEnable  in  1  regfile write enable.
- ctrl_writeReg  in  5  regfile destination register.
- data_writeReg  in  32  regfile write data.
- capture_en  in  1  enables capture; when 0, writebacks are ignored entirely.
- clear  in  1  synchronous flush.
- out_ready  in  1  host accepts the current record.
- out_valid  out  1  a record is available.
- out_data  out  SEQ_W+37  record = {seq, reg[4:0], data[31:0]}; 48 bits at defaults.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one record has been dropped.
- drop_count  out  16  number of dropped records, saturating.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - out_valid=0, count=0, overflow=0, drop_count=0.
  - seq=0; both read and write pointers=0.
  - out_data is don't-care while out_valid=0.
  - Storage contents need not be reset.
- Eligible event on a clock edge: capture_en & ctrl_writeEnable & (ctrl_writeReg != 0). Writes to r0 are never recorded and never consume a sequence number.
- Every eligible event consumes one sequence number: seq increments mod 2^SEQ_W, whether the record is stored or dropped. Gaps in seq reveal drops to the host.
- Pop occurs on an edge where out_valid & out_ready.
- Push is accepted when the event is eligible and (count<DEPTH or pop occurs on the same edge). The stored record carries the pre-increment seq.
- Push rejected because the FIFO is full with no pop: record is discarded; overflow<=1; drop_count increments, saturating at 16'hFFFF.
- Simultaneous push and pop: count is unchanged; both pointers advance. This is legal when full and when count=1.
- Push while count=0: no fall-through. out_valid rises on the edge after the push, and out_data then shows that record.
- out_valid = (count != 0), driven from registered state. out_data = mem[rd_ptr], combinational from storage.
- Once out_valid is asserted, out_data is held stable until popped.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. count carries the full/empty distinction.
- clear=1 on an edge:
  - Empties the FIFO (pointers and count to 0); zeroes seq, overflow and drop_count.
  - Any push or pop on that edge is ignored; clear has priority.
- Reset asserted mid-drain: all state returns to reset values immediately. A record in flight is lost, and the host must treat out_valid falling without a handshake as a flush.
- capture_en deasserted: capture stops; the drain continues normally.
- Latency: writeback to out_valid is one edge when the FIFO is empty. Throughput is one push and one pop per cycle.

Decomposition:
- Shared package trace_pkg:
  - Record field widths: REG_W=5, DATA_W=32, SEQ_W.
  - Record bit offsets.
  - Drop counter width 16.
- One sub-module: trace_fifo.
  - Generic DEPTH x WIDTH register-array FIFO with push/pop/clear, count, full and empty.
  - wb_trace_buffer adds the eligibility filter, seq tagging, drop accounting and the saturating counter.

Test Plan:
- Reset, then single write r3=0x0000_00AA with out_ready=0 → next cycle out_valid=1, out_data={11'd0,5'd3,32'hAA}, count=1. Then out_ready=1 for one cycle → count=0, out_valid=0.
- Write r0=0xFFFF_FFFF, then r1=0x5 → only r1 is recorded, with seq=0. Next eligible write gets seq=1.
- 20 eligible writes with out_ready=0 → count=16, overflow=1, drop_count=4. Drained records carry seq 0..15. Write #21 gets seq=20.
- FIFO full with out_ready=1 and a new write on the same edge → record accepted, count stays 16, drop_count unchanged. Wrap: pointers pass index 15→0 and records drain in order.
- clear pulsed with count=7 and a simultaneous write → count=0, seq=0, overflow=0, drop_count=0, out_valid=0 next cycle. The next write gets seq=0.
- reset driven low mid-stream, between clock edges → out_valid, count and overflow go to 0 without waiting for an edge. After release, the first write gets seq=0.
